// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the shared-memory access controller.
// Imported by the controller top and its round-robin arbiter.
package mem_ctrl_pkg;

    localparam int AW_DEFAULT = 64;
    localparam int DW_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_e;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin arbiter: combinational pick between fetch and data,
// plus the register remembering which requester was granted last.
module mem_rr_arb
    import mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_if,
    input  logic req_d,
    input  logic grant_en,
    output logic gnt_valid,
    output logic gnt_d
);

    req_e last_r;
    req_e pick_s;

    // Pick the sole requester, or on a tie the one not granted last.
    always_comb begin
        case ({req_if, req_d})
            2'b10:   pick_s = REQ_IF;
            2'b01:   pick_s = REQ_D;
            2'b11:   pick_s = (last_r == REQ_IF) ? REQ_D : REQ_IF;
            default: pick_s = REQ_IF;
        endcase
    end

    assign gnt_valid = req_if | req_d;
    assign gnt_d     = (pick_s == REQ_D);

    // Remember the winner of every accepted grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r <= REQ_IF;
        end else if (grant_en && gnt_valid) begin
            last_r <= pick_s;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares one memory port between an instruction-fetch and a data requester,
// with fixed-latency accesses, round-robin arbitration and an overrun flag.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = AW_DEFAULT,
    parameter int DW      = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] rdata,
    output logic          if_done,
    output logic          d_done,
    output logic          busy,
    output logic          overrun
);

    localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

    state_e        state_r;
    state_e        state_nxt_s;
    logic [2:0]    cnt_r;
    req_e          gsel_r;
    logic          we_r;
    logic          if_pend_r;
    logic          d_pend_r;
    logic          if_pend_nxt_s;
    logic          d_pend_nxt_s;
    logic          if_inflight_s;
    logic          d_inflight_s;
    logic          if_ovr_s;
    logic          d_ovr_s;
    logic          take_if_s;
    logic          take_d_s;
    logic          last_acc_s;
    logic          gnt_valid_s;
    logic          gnt_d_s;
    req_e          gnt_s;
    logic [AW-1:0] mem_addr_r;
    logic          mem_wr_r;
    logic [DW-1:0] mem_wdata_r;
    logic [DW-1:0] rdata_r;
    logic          if_done_r;
    logic          d_done_r;
    logic          busy_r;
    logic          overrun_r;

    mem_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_if    (if_pend_r),
        .req_d     (d_pend_r),
        .grant_en  (state_r == IDLE),
        .gnt_valid (gnt_valid_s),
        .gnt_d     (gnt_d_s)
    );

    assign gnt_s         = gnt_d_s ? REQ_D : REQ_IF;
    assign if_inflight_s = (state_r != IDLE) && (gsel_r == REQ_IF);
    assign d_inflight_s  = (state_r != IDLE) && (gsel_r == REQ_D);
    assign if_ovr_s      = if_req && (if_pend_r || if_inflight_s);
    assign d_ovr_s       = d_req && (d_pend_r || d_inflight_s);
    assign take_if_s     = (state_r == IDLE) && gnt_valid_s && (gnt_s == REQ_IF);
    assign take_d_s      = (state_r == IDLE) && gnt_valid_s && (gnt_s == REQ_D);
    assign last_acc_s    = (cnt_r == CNT_LAST);

    // Pending bits: a grant clears, an accepted pulse sets, an overrun pulse is dropped.
    always_comb begin
        if (take_if_s) begin
            if_pend_nxt_s = 1'b0;
        end else if (if_req && !if_ovr_s) begin
            if_pend_nxt_s = 1'b1;
        end else begin
            if_pend_nxt_s = if_pend_r;
        end
        if (take_d_s) begin
            d_pend_nxt_s = 1'b0;
        end else if (d_req && !d_ovr_s) begin
            d_pend_nxt_s = 1'b1;
        end else begin
            d_pend_nxt_s = d_pend_r;
        end
    end

    // Next FSM state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (last_acc_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Controller FSM with all outputs registered; busy is computed from next-state values
    // so it tracks the registered state and pending bits in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            gsel_r      <= REQ_IF;
            we_r        <= 1'b0;
            if_pend_r   <= 1'b0;
            d_pend_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wr_r    <= 1'b0;
            mem_wdata_r <= '0;
            rdata_r     <= '0;
            if_done_r   <= 1'b0;
            d_done_r    <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            if_pend_r <= if_pend_nxt_s;
            d_pend_r  <= d_pend_nxt_s;
            busy_r    <= (state_nxt_s != IDLE) || if_pend_nxt_s || d_pend_nxt_s;
            overrun_r <= overrun_r | if_ovr_s | d_ovr_s;
            if_done_r <= 1'b0;
            d_done_r  <= 1'b0;
            mem_wr_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (gnt_valid_s) begin
                        gsel_r <= gnt_s;
                        cnt_r  <= 3'd0;
                        if (gnt_s == REQ_D) begin
                            we_r        <= d_we;
                            mem_addr_r  <= d_addr;
                            mem_wdata_r <= d_we ? d_wdata : '0;
                            mem_wr_r    <= d_we;
                        end else begin
                            we_r        <= 1'b0;
                            mem_addr_r  <= if_addr;
                            mem_wdata_r <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (last_acc_s) begin
                        mem_addr_r  <= '0;
                        mem_wdata_r <= '0;
                        if (!we_r) begin
                            rdata_r <= mem_rdata;
                        end
                        if_done_r <= (gsel_r == REQ_IF);
                        d_done_r  <= (gsel_r == REQ_D);
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                DONE: begin
                    mem_addr_r  <= '0;
                    mem_wdata_r <= '0;
                end
                default: begin
                    mem_addr_r  <= '0;
                    mem_wdata_r <= '0;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_wr    = mem_wr_r;
    assign mem_wdata = mem_wdata_r;
    assign rdata     = rdata_r;
    assign if_done   = if_done_r;
    assign d_done    = d_done_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a per-cycle vector table at MEM_LAT=1 plus
// hand-written sequences for ties, overrun, a MEM_LAT=3 instance and mid-access reset.
module tb_mem_access_ctrl;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;

    logic [AW-1:0] mem_addr, mem_addr3;
    logic          mem_wr, mem_wr3;
    logic [DW-1:0] mem_wdata, mem_wdata3, rdata, rdata3;
    logic          if_done, if_done3, d_done, d_done3, busy, busy3, overrun, overrun3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LAT(1), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .rdata(rdata), .if_done(if_done),
        .d_done(d_done), .busy(busy), .overrun(overrun)
    );

    mem_access_ctrl #(.MEM_LAT(3), .AW(AW), .DW(DW)) dut3 (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr3), .mem_wr(mem_wr3),
        .mem_wdata(mem_wdata3), .rdata(rdata3), .if_done(if_done3),
        .d_done(d_done3), .busy(busy3), .overrun(overrun3)
    );

    typedef struct {
        logic        if_req;
        logic [63:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [63:0] d_addr;
        logic [63:0] d_wdata;
        logic [63:0] mem_rd;
        logic [63:0] e_addr;
        logic        e_wr;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
        logic        e_ifd;
        logic        e_dd;
        logic        e_busy;
    } vec_t;

    typedef logic log_t [16];
    typedef logic [63:0] log64_t [16];

    vec_t   vecs [15];
    log_t   log_if, log_d, log_wr, log_d3, log_ovr;
    log64_t log_rd, log_rd3;

    function automatic vec_t mk(input logic ir, input logic [63:0] ia, input logic dr,
                                input logic dw, input logic [63:0] da, input logic [63:0] dwd,
                                input logic [63:0] mr, input logic [63:0] ea, input logic ew,
                                input logic [63:0] ewd, input logic [63:0] er,
                                input logic eif, input logic ed, input logic eb);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia; v.d_req = dr; v.d_we = dw;
        v.d_addr = da;  v.d_wdata = dwd; v.mem_rd = mr;
        v.e_addr = ea;  v.e_wr = ew; v.e_wdata = ewd; v.e_rdata = er;
        v.e_ifd = eif;  v.e_dd = ed; v.e_busy = eb;
        return v;
    endfunction

    function automatic int first_idx(input log_t a);
        for (int i = 0; i < 16; i++) if (a[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_hi(input log_t a, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (a[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic check64(input string name, input int idx, input logic [63:0] act,
                           input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Run ncyc cycles from the current one (cycle 0 carries whatever requests the caller set),
    // optionally injecting an extra d_req in cycle dreq2; mem_rdata = 0x1000 + cycle.
    task automatic run(input int ncyc, input int dreq2);
        for (int c = 0; c < ncyc; c++) begin
            mem_rdata = 64'h1000 + 64'(c);
            if (c == dreq2) d_req = 1'b1;
            @(negedge clk);
            log_if[c] = if_done;  log_d[c] = d_done;  log_wr[c] = mem_wr;
            log_d3[c] = d_done3;  log_ovr[c] = overrun;
            log_rd[c] = rdata;    log_rd3[c] = rdata3;
            @(posedge clk);
            #1;
            if_req = 1'b0;
            d_req  = 1'b0;
        end
    endtask

    initial begin
        // Fetch, then store, then load, all at MEM_LAT=1, one row per cycle.
        vecs[0]  = mk(1'b1, 64'h100, 1'b0, 1'b0, 64'h0,   64'h0,    64'h13,   64'h0,   1'b0, 64'h0,    64'h0,    1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 64'h100, 1'b0, 1'b0, 64'h0,   64'h0,    64'h13,   64'h0,   1'b0, 64'h0,    64'h0,    1'b0, 1'b0, 1'b1);
        vecs[2]  = mk(1'b0, 64'h100, 1'b0, 1'b0, 64'h0,   64'h0,    64'h13,   64'h100, 1'b0, 64'h0,    64'h0,    1'b0, 1'b0, 1'b1);
        vecs[3]  = mk(1'b0, 64'h100, 1'b0, 1'b0, 64'h0,   64'h0,    64'h13,   64'h0,   1'b0, 64'h0,    64'h13,   1'b1, 1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   64'h0,    64'h13,   64'h0,   1'b0, 64'h0,    64'h13,   1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 64'h0,   1'b1, 1'b1, 64'h200, 64'hDEAD, 64'h77,   64'h0,   1'b0, 64'h0,    64'h13,   1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 64'h0,   1'b0, 1'b1, 64'h200, 64'hDEAD, 64'h77,   64'h0,   1'b0, 64'h0,    64'h13,   1'b0, 1'b0, 1'b1);
        vecs[7]  = mk(1'b0, 64'h0,   1'b0, 1'b1, 64'h200, 64'hDEAD, 64'h77,   64'h200, 1'b1, 64'hDEAD, 64'h13,   1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 64'h0,   1'b0, 1'b1, 64'h200, 64'hDEAD, 64'h77,   64'h0,   1'b0, 64'h0,    64'h13,   1'b0, 1'b1, 1'b1);
        vecs[9]  = mk(1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   64'h0,    64'h77,   64'h0,   1'b0, 64'h0,    64'h13,   1'b0, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 64'h0,   1'b1, 1'b0, 64'h300, 64'h0,    64'h55AA, 64'h0,   1'b0, 64'h0,    64'h13,   1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 64'h0,   1'b0, 1'b0, 64'h300, 64'h0,    64'h55AA, 64'h0,   1'b0, 64'h0,    64'h13,   1'b0, 1'b0, 1'b1);
        vecs[12] = mk(1'b0, 64'h0,   1'b0, 1'b0, 64'h300, 64'h0,    64'h55AA, 64'h300, 1'b0, 64'h0,    64'h13,   1'b0, 1'b0, 1'b1);
        vecs[13] = mk(1'b0, 64'h0,   1'b0, 1'b0, 64'h300, 64'h0,    64'h55AA, 64'h0,   1'b0, 64'h0,    64'h55AA, 1'b0, 1'b1, 1'b1);
        vecs[14] = mk(1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   64'h0,    64'h55AA, 64'h0,   1'b0, 64'h0,    64'h55AA, 1'b0, 1'b0, 1'b0);

        // Reset state.
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check64("rst_mem_addr", -1, mem_addr, 64'h0);
        check64("rst_mem_wdata", -1, mem_wdata, 64'h0);
        check64("rst_rdata", -1, rdata, 64'h0);
        check64("rst_flags", -1, 64'({mem_wr, if_done, d_done, busy, overrun}), 64'h0);
        check64("rst_flags3", -1, 64'({mem_wr3, if_done3, d_done3, busy3, overrun3}), 64'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Table-driven fetch / store / load.
        for (int i = 0; i < 15; i++) begin
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            d_req = vecs[i].d_req;   d_we = vecs[i].d_we;
            d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
            mem_rdata = vecs[i].mem_rd;
            @(negedge clk);
            check64("mem_addr", i, mem_addr, vecs[i].e_addr);
            check64("mem_wr", i, 64'(mem_wr), 64'(vecs[i].e_wr));
            check64("mem_wdata", i, mem_wdata, vecs[i].e_wdata);
            check64("rdata", i, rdata, vecs[i].e_rdata);
            check64("if_done", i, 64'(if_done), 64'(vecs[i].e_ifd));
            check64("d_done", i, 64'(d_done), 64'(vecs[i].e_dd));
            check64("busy", i, 64'(busy), 64'(vecs[i].e_busy));
            @(posedge clk);
            #1;
        end

        // Tie right after reset: data first, then fetch.
        do_reset();
        if_addr = 64'h10; d_addr = 64'h20; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        run(10, -1);
        check_int("tie1_d_done_cycle", first_idx(log_d), 3);
        check_int("tie1_if_done_cycle", first_idx(log_if), 6);
        check_int("tie1_if_done_count", count_hi(log_if, 10), 1);
        check64("tie1_d_rdata", 3, log_rd[3], 64'h1002);
        check64("tie1_if_rdata", 6, log_rd[6], 64'h1005);

        // A lone data access makes data the last grant; the following tie goes to fetch.
        d_req = 1'b1;
        run(6, -1);
        check_int("lone_d_done_cycle", first_idx(log_d), 3);
        if_req = 1'b1; d_req = 1'b1;
        run(10, -1);
        check_int("tie2_if_done_cycle", first_idx(log_if), 3);
        check_int("tie2_d_done_cycle", first_idx(log_d), 6);
        check_int("tie2_no_overlap", count_hi(log_if, 10) + count_hi(log_d, 10), 2);

        // Overrun: a second d_req during the store's ACCESS cycle.
        do_reset();
        d_we = 1'b1; d_addr = 64'h80; d_wdata = 64'h55; d_req = 1'b1;
        run(8, 2);
        check_int("ovr_d_done_count", count_hi(log_d, 8), 1);
        check_int("ovr_mem_wr_count", count_hi(log_wr, 8), 1);
        check_int("ovr_before", int'(log_ovr[2]), 0);
        check_int("ovr_set", int'(log_ovr[3]), 1);
        run(4, -1);
        @(negedge clk);
        check64("ovr_sticky", -1, 64'(overrun), 64'h1);
        do_reset();
        @(negedge clk);
        check64("ovr_cleared", -1, 64'(overrun), 64'h0);
        @(posedge clk);
        #1;

        // Latency sweep: load from 0x40 on both instances.
        d_we = 1'b0; d_addr = 64'h40; d_req = 1'b1;
        run(8, -1);
        check_int("lat3_d_done_cycle", first_idx(log_d3), 5);
        check_int("lat3_d_done_count", count_hi(log_d3, 8), 1);
        check64("lat3_rdata", 5, log_rd3[5], 64'h1004);
        check_int("lat1_d_done_cycle", first_idx(log_d), 3);
        check64("lat1_rdata", 3, log_rd[3], 64'h1002);

        // Reset during a store's ACCESS: outputs drop without a clock edge.
        do_reset();
        d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'hDEAD; d_req = 1'b1;
        @(posedge clk);
        #1 d_req = 1'b0;
        @(posedge clk);
        #1;
        check64("mid_wr_before", -1, 64'(mem_wr), 64'h1);
        #2 reset = 1'b0;
        #1;
        check64("mid_wr_async", -1, 64'({mem_wr, mem_wr3}), 64'h0);
        check64("mid_busy_async", -1, 64'({busy, busy3}), 64'h0);
        check64("mid_addr_async", -1, mem_addr, 64'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check64("mid_no_done", c, 64'({d_done, d_done3, if_done, if_done3}), 64'h0);
        end
        clear_inputs();
        @(posedge clk);
        #1 reset = 1'b1;
        if_addr = 64'h300; if_req = 1'b1;
        run(6, -1);
        check_int("post_rst_if_done_cycle", first_idx(log_if), 3);
        check64("post_rst_rdata", 3, log_rd[3], 64'h1002);
        check_int("post_rst_no_d_done", count_hi(log_d, 6), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
